// File: rtl/vector_decode_unit.sv
// Decode stage with scalar and vector register files, same-cycle write-back
// bypass, a per-register busy scoreboard and a single registered output slot
// handshaked with valid/ready on both the fetch and execute sides.
module vector_decode_unit #(
    parameter int WIDTH            = 24,
    parameter int LANES            = 8,
    parameter int SREGNUM          = 16,
    parameter int VREGNUM          = 16,
    parameter int ADDRESSWIDTH     = 4,
    parameter int OPCODEWIDTH      = 4,
    parameter int INSTRUCTIONWIDTH = 24,
    localparam int IDXW            = $clog2(LANES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTRUCTIONWIDTH-1:0] instruction,
    input  logic [WIDTH-1:0]            PC,
    input  logic                        writeEnable,
    input  logic [ADDRESSWIDTH-1:0]     writeAddress,
    input  logic                        isvector_A,
    input  logic                        vect_esc_A,
    input  logic [IDXW-1:0]             index_A,
    input  logic [WIDTH-1:0]            dataToSave,
    input  logic [LANES*WIDTH-1:0]      dataToSave_v,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPCODEWIDTH-1:0]      opcode,
    output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
    output logic [ADDRESSWIDTH-1:0]     reg1Address,
    output logic [ADDRESSWIDTH-1:0]     reg2Address,
    output logic [WIDTH-1:0]            reg1Content,
    output logic [WIDTH-1:0]            reg2Content,
    output logic [LANES*WIDTH-1:0]      data_out,
    output logic [LANES*WIDTH-1:0]      data_out2,
    output logic [WIDTH-1:0]            inmediate,
    output logic                        isvector,
    output logic                        vect_esc,
    output logic [IDXW-1:0]             index1,
    output logic [WIDTH-1:0]            PC_out
);

    // Register files and scoreboard
    logic [WIDTH-1:0]       r_sreg [SREGNUM];
    logic [LANES*WIDTH-1:0] r_vreg [VREGNUM];
    logic [SREGNUM-1:0]     r_sbusy;
    logic [VREGNUM-1:0]     r_vbusy;

    // Output slot
    logic                    r_out_valid;
    logic [OPCODEWIDTH-1:0]  r_opcode;
    logic [ADDRESSWIDTH-1:0] r_rd, r_rs1, r_rs2;
    logic [WIDTH-1:0]        r_reg1, r_reg2, r_imm, r_pc;
    logic [LANES*WIDTH-1:0]  r_data1, r_data2;
    logic                    r_isvector, r_vect_esc;
    logic [IDXW-1:0]         r_index;

    // Instruction fields
    logic [OPCODEWIDTH-1:0]  w_op;
    logic [ADDRESSWIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic                    w_isv, w_esc;
    assign w_op  = instruction[23 -: OPCODEWIDTH];
    assign w_rd  = instruction[19 -: ADDRESSWIDTH];
    assign w_rs1 = instruction[15 -: ADDRESSWIDTH];
    assign w_rs2 = instruction[11 -: ADDRESSWIDTH];
    assign w_isv = instruction[4];
    assign w_esc = instruction[3];

    function automatic logic f_s_ok(input logic [ADDRESSWIDTH-1:0] a);
        return 32'(a) < SREGNUM;
    endfunction

    function automatic logic f_v_ok(input logic [ADDRESSWIDTH-1:0] a);
        return 32'(a) < VREGNUM;
    endfunction

    // Write-back classification; scalar 0 and out-of-range addresses never store
    logic w_s_wr, w_v_full, w_v_elem;
    assign w_s_wr   = writeEnable && !isvector_A && (writeAddress != '0) && f_s_ok(writeAddress);
    assign w_v_full = writeEnable && isvector_A && !vect_esc_A && f_v_ok(writeAddress);
    assign w_v_elem = writeEnable && isvector_A && vect_esc_A && f_v_ok(writeAddress);

    // Per-register busy clear from this cycle's write-back
    logic [SREGNUM-1:0] w_sclr, w_sset;
    logic [VREGNUM-1:0] w_vclr, w_vset;
    logic               w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < SREGNUM; gi++) begin : g_sbusy
            assign w_sclr[gi] = writeEnable && !isvector_A && (writeAddress == ADDRESSWIDTH'(gi));
            assign w_sset[gi] = (gi != 0) && w_accept && (w_op != '0) && !w_isv
                                && (w_rd == ADDRESSWIDTH'(gi));
        end
        for (gi = 0; gi < VREGNUM; gi++) begin : g_vbusy
            assign w_vclr[gi] = writeEnable && isvector_A && (writeAddress == ADDRESSWIDTH'(gi));
            assign w_vset[gi] = w_accept && (w_op != '0) && w_isv
                                && (w_rd == ADDRESSWIDTH'(gi));
        end
    endgenerate

    logic [SREGNUM-1:0] w_sbusy_eff;
    logic [VREGNUM-1:0] w_vbusy_eff;
    assign w_sbusy_eff = r_sbusy & ~w_sclr;
    assign w_vbusy_eff = r_vbusy & ~w_vclr;

    function automatic logic f_busy(input logic vec, input logic [ADDRESSWIDTH-1:0] a);
        if (vec) return f_v_ok(a) && w_vbusy_eff[a];
        return f_s_ok(a) && w_sbusy_eff[a];
    endfunction

    // Scalar read with write-back bypass
    function automatic logic [WIDTH-1:0] f_sread(input logic [ADDRESSWIDTH-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (a != '0 && f_s_ok(a)) begin
            if (w_s_wr && writeAddress == a) v = dataToSave;
            else                             v = r_sreg[a];
        end
        return v;
    endfunction

    // Vector read with full or element-merge bypass
    function automatic logic [LANES*WIDTH-1:0] f_vread(input logic [ADDRESSWIDTH-1:0] a);
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        if (f_v_ok(a)) begin
            v = r_vreg[a];
            if (w_v_full && writeAddress == a)
                v = dataToSave_v;
            else if (w_v_elem && writeAddress == a)
                v[index_A*WIDTH +: WIDTH] = dataToSave;
        end
        return v;
    endfunction

    // Hazard: any referenced register busy in its class; NOP checks nothing
    logic w_hazard;
    always_comb begin
        w_hazard = 1'b0;
        if (in_valid && w_op != '0)
            w_hazard = f_busy(w_isv, w_rd) || f_busy(w_isv, w_rs1)
                       || f_busy(w_isv && !w_esc, w_rs2);
    end

    assign in_ready = !w_hazard && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Register-file write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SREGNUM; i++) r_sreg[i] <= '0;
            for (int i = 0; i < VREGNUM; i++) r_vreg[i] <= '0;
        end else begin
            if (w_s_wr)
                r_sreg[writeAddress] <= dataToSave;
            if (w_v_full)
                r_vreg[writeAddress] <= dataToSave_v;
            else if (w_v_elem)
                r_vreg[writeAddress][index_A*WIDTH +: WIDTH] <= dataToSave;
        end
    end

    // Scoreboard update: clear on write-back, set on accept (set wins)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sbusy <= '0;
            r_vbusy <= '0;
        end else begin
            r_sbusy <= w_sbusy_eff | w_sset;
            r_vbusy <= w_vbusy_eff | w_vset;
        end
    end

    // Output slot: load on accept, drop on consume, otherwise hold
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_isvector  <= 1'b0;
            r_vect_esc  <= 1'b0;
            r_index     <= '0;
            r_pc        <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_op;
            r_rd        <= w_rd;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_reg1      <= f_sread(w_rs1);
            r_reg2      <= f_sread(w_rs2);
            r_data1     <= f_vread(w_rs1);
            r_data2     <= f_vread(w_rs2);
            r_imm       <= WIDTH'(instruction[11:0]);
            r_isvector  <= w_isv;
            r_vect_esc  <= w_esc;
            r_index     <= instruction[IDXW-1:0];
            r_pc        <= PC;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid             = r_out_valid;
    assign opcode                = r_opcode;
    assign regDestinationAddress = r_rd;
    assign reg1Address           = r_rs1;
    assign reg2Address           = r_rs2;
    assign reg1Content           = r_reg1;
    assign reg2Content           = r_reg2;
    assign data_out              = r_data1;
    assign data_out2             = r_data2;
    assign inmediate             = r_imm;
    assign isvector              = r_isvector;
    assign vect_esc              = r_vect_esc;
    assign index1                = r_index;
    assign PC_out                = r_pc;

endmodule

// File: tb/tb_vector_decode_unit.sv
// Bench for vector_decode_unit: directed scenarios followed by randomized
// traffic, all compared against a register-file/scoreboard model.
module tb_vector_decode_unit;

    localparam int W  = 24;
    localparam int L  = 8;
    localparam int LW = W * L;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [23:0]   instruction;
    logic [W-1:0]  PC;
    logic          writeEnable;
    logic [3:0]    writeAddress;
    logic          isvector_A, vect_esc_A;
    logic [2:0]    index_A;
    logic [W-1:0]  dataToSave;
    logic [LW-1:0] dataToSave_v;
    logic          out_valid, out_ready;
    logic [3:0]    opcode, regDestinationAddress, reg1Address, reg2Address;
    logic [W-1:0]  reg1Content, reg2Content, inmediate, PC_out;
    logic [LW-1:0] data_out, data_out2;
    logic          isvector, vect_esc;
    logic [2:0]    index1;

    vector_decode_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .PC(PC), .writeEnable(writeEnable),
        .writeAddress(writeAddress), .isvector_A(isvector_A), .vect_esc_A(vect_esc_A),
        .index_A(index_A), .dataToSave(dataToSave), .dataToSave_v(dataToSave_v),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .regDestinationAddress(regDestinationAddress), .reg1Address(reg1Address),
        .reg2Address(reg2Address), .reg1Content(reg1Content), .reg2Content(reg2Content),
        .data_out(data_out), .data_out2(data_out2), .inmediate(inmediate),
        .isvector(isvector), .vect_esc(vect_esc), .index1(index1), .PC_out(PC_out)
    );

    always #5 clock = ~clock;

    // Reference state
    logic [W-1:0] sref [16];
    logic [W-1:0] vref [16][L];
    bit           sb [16];
    bit           vb [16];

    // Expected output slot
    bit            e_valid, e_isv, e_esc;
    logic [3:0]    e_op, e_rd, e_rs1, e_rs2;
    logic [W-1:0]  e_imm, e_pc, e_r1, e_r2;
    logic [2:0]    e_idx;
    logic [LW-1:0] e_d1, e_d2;
    bit            m_r1, m_r2, m_d1, m_d2;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input int isv, input int esc, input int idx);
        return {4'(op), 4'(rd), 4'(rs1), 4'(rs2), 3'b000, 1'(isv), 1'(esc), 3'(idx)};
    endfunction

    function automatic logic [LW-1:0] vpack(input int r);
        logic [LW-1:0] v;
        for (int l = 0; l < L; l++) v[l*W +: W] = vref[r][l];
        return v;
    endfunction

    task automatic idle();
        in_valid = 0; instruction = '0; PC = '0; out_ready = 1;
        writeEnable = 0; writeAddress = '0; isvector_A = 0; vect_esc_A = 0;
        index_A = '0; dataToSave = '0; dataToSave_v = '0;
    endtask

    task automatic wr_s(input int a, input int d);
        writeEnable = 1; isvector_A = 0; vect_esc_A = 0;
        writeAddress = 4'(a); dataToSave = W'(d);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            sref[i] = '0; sb[i] = 0; vb[i] = 0;
            for (int l = 0; l < L; l++) vref[i][l] = '0;
        end
        e_valid = 0; e_isv = 0; e_esc = 0; e_op = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0;
        e_imm = '0; e_pc = '0; e_r1 = '0; e_r2 = '0; e_idx = '0; e_d1 = '0; e_d2 = '0;
        m_r1 = 1; m_r2 = 1; m_d1 = 1; m_d2 = 1;
    endtask

    task automatic check_slot();
        check("out_valid", 256'(out_valid), 256'(e_valid));
        check("opcode", 256'(opcode), 256'(e_op));
        check("rd", 256'(regDestinationAddress), 256'(e_rd));
        check("rs1", 256'(reg1Address), 256'(e_rs1));
        check("rs2", 256'(reg2Address), 256'(e_rs2));
        check("imm", 256'(inmediate), 256'(e_imm));
        check("isvector", 256'(isvector), 256'(e_isv));
        check("vect_esc", 256'(vect_esc), 256'(e_esc));
        check("index1", 256'(index1), 256'(e_idx));
        check("pc_out", 256'(PC_out), 256'(e_pc));
        if (m_r1) check("reg1", 256'(reg1Content), 256'(e_r1));
        if (m_r2) check("reg2", 256'(reg2Content), 256'(e_r2));
        if (m_d1) check("data_out", 256'(data_out), 256'(e_d1));
        if (m_d2) check("data_out2", 256'(data_out2), 256'(e_d2));
    endtask

    // One clock of traffic: inputs are already driven by the caller
    task automatic step();
        int  op, rd, rs1, rs2, a;
        bit  isv, esc, haz, rdy;
        #1;
        // write-back lands first, so reads and hazards see the post-write state
        if (writeEnable) begin
            a = int'(writeAddress);
            if (!isvector_A) begin
                if (a != 0) sref[a] = dataToSave;
                sb[a] = 0;
            end else begin
                if (!vect_esc_A)
                    for (int l = 0; l < L; l++) vref[a][l] = dataToSave_v[l*W +: W];
                else
                    vref[a][index_A] = dataToSave;
                vb[a] = 0;
            end
        end
        op  = int'(instruction[23:20]);
        rd  = int'(instruction[19:16]);
        rs1 = int'(instruction[15:12]);
        rs2 = int'(instruction[11:8]);
        isv = instruction[4];
        esc = instruction[3];
        haz = in_valid && op != 0 &&
              ((isv ? vb[rd] : sb[rd]) || (isv ? vb[rs1] : sb[rs1]) ||
               ((isv && !esc) ? vb[rs2] : sb[rs2]));
        rdy = !haz && (!e_valid || out_ready);
        check("in_ready", 256'(in_ready), 256'(rdy));
        if (in_valid && rdy) begin
            e_valid = 1; e_op = 4'(op); e_rd = 4'(rd); e_rs1 = 4'(rs1); e_rs2 = 4'(rs2);
            e_imm = W'(instruction[11:0]); e_isv = isv; e_esc = esc;
            e_idx = instruction[2:0]; e_pc = PC;
            m_r1 = !isv;         e_r1 = sref[rs1];
            m_r2 = !isv || esc;  e_r2 = sref[rs2];
            m_d1 = isv;          e_d1 = vpack(rs1);
            m_d2 = isv && !esc;  e_d2 = vpack(rs2);
            if (op != 0) begin
                if (isv) vb[rd] = 1;
                else if (rd != 0) sb[rd] = 1;
            end
        end else if (out_ready) begin
            e_valid = 0;
        end
        @(posedge clock);
        #1;
        check_slot();
    endtask

    // Reset with a live write-back and instruction that must both be ignored
    task automatic do_reset();
        reset = 1; in_valid = 1; instruction = mk(1, 4, 4, 4, 1, 0, 0);
        writeEnable = 1; isvector_A = 0; writeAddress = 4'd3; dataToSave = 24'h123;
        @(posedge clock);
        #1;
        reset = 0;
        idle();
        model_clear();
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check_slot();
    endtask

    int vals [8] = '{2, 1, 6, 4, 8, 4, 3, 2};

    initial begin
        idle();
        reset = 1;
        model_clear();
        @(posedge clock);
        do_reset();

        // scalar bypass
        wr_s(3, 9); step();
        idle(); wr_s(2, 5); step();
        idle(); in_valid = 1; instruction = mk(0, 0, 3, 2, 0, 0, 0); wr_s(2, 7); step();
        check("bypass_r1", 256'(reg1Content), 256'(9));
        check("bypass_r2", 256'(reg2Content), 256'(7));

        // vector write then element merge
        idle(); writeEnable = 1; isvector_A = 1; vect_esc_A = 0; writeAddress = 4'd4;
        for (int l = 0; l < L; l++) dataToSave_v[l*W +: W] = W'(vals[l]);
        step();
        idle(); writeEnable = 1; isvector_A = 1; vect_esc_A = 1; writeAddress = 4'd4;
        index_A = 3'd2; dataToSave = 24'd10; step();
        idle(); in_valid = 1; instruction = mk(0, 0, 4, 4, 1, 0, 0); step();
        check("vmerge_lane2", 256'(data_out[2*W +: W]), 256'(10));
        check("vmerge_lane4", 256'(data_out[4*W +: W]), 256'(vals[4]));

        // scoreboard stall released by write-back, value bypassed
        idle(); in_valid = 1; instruction = mk(1, 5, 0, 0, 0, 0, 0); step();
        idle(); in_valid = 1; instruction = mk(2, 1, 5, 0, 0, 0, 0); step(); step();
        check("stall_held", 256'(in_ready), 256'(0));
        wr_s(5, 33); step();
        check("stall_bypass", 256'(reg1Content), 256'(33));

        // backpressure
        do_reset();
        in_valid = 1; instruction = mk(0, 1, 2, 3, 0, 0, 0); PC = 24'd100; step();
        out_ready = 0; instruction = mk(0, 2, 3, 4, 0, 0, 0); PC = 24'd200;
        repeat (3) step();
        check("bp_hold_pc", 256'(PC_out), 256'(100));
        out_ready = 1; step();
        check("bp_release_pc", 256'(PC_out), 256'(200));

        // register 0 and NOP
        idle(); wr_s(0, 9); in_valid = 1; instruction = mk(0, 0, 0, 0, 0, 0, 0); step();
        idle(); in_valid = 1; instruction = mk(1, 0, 0, 0, 0, 0, 0); step();
        idle(); in_valid = 1; instruction = mk(1, 6, 0, 0, 0, 0, 0); step();
        check("r0_read", 256'(reg1Content), 256'(0));

        // reset mid-stream with v4 busy
        idle(); writeEnable = 1; isvector_A = 1; writeAddress = 4'd4;
        dataToSave_v = {8{24'h00ABCD}}; step();
        idle(); in_valid = 1; instruction = mk(1, 4, 0, 0, 1, 0, 0); step();
        do_reset();
        in_valid = 1; instruction = mk(0, 0, 4, 4, 1, 0, 0); step();
        check("rst_v4", 256'(data_out), 256'(0));

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                in_valid     = ($urandom_range(0, 3) != 0);
                instruction  = mk($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                                  $urandom_range(0, 7));
                PC           = W'($urandom);
                writeEnable  = ($urandom_range(0, 1) != 0);
                writeAddress = 4'($urandom_range(0, 7));
                isvector_A   = 1'($urandom_range(0, 1));
                vect_esc_A   = 1'($urandom_range(0, 1));
                index_A      = 3'($urandom_range(0, 7));
                dataToSave   = W'($urandom);
                for (int l = 0; l < L; l++) dataToSave_v[l*W +: W] = W'($urandom);
                out_ready    = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
